// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - DLX opcode/func encodings, ALU/branch enums and pipeline register structs
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDUI = 6'h09;
  localparam logic [5:0] OP_SUBI  = 6'h0a;
  localparam logic [5:0] OP_SUBUI = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LHI   = 6'h0f;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] OP_SLLI  = 6'h14;
  localparam logic [5:0] OP_SRLI  = 6'h16;
  localparam logic [5:0] OP_SRAI  = 6'h17;
  localparam logic [5:0] OP_SEQI  = 6'h18;
  localparam logic [5:0] OP_SNEI  = 6'h19;
  localparam logic [5:0] OP_SLTI  = 6'h1a;
  localparam logic [5:0] OP_SGTI  = 6'h1b;
  localparam logic [5:0] OP_SLEI  = 6'h1c;
  localparam logic [5:0] OP_SGEI  = 6'h1d;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h04;
  localparam logic [5:0] FN_SRL  = 6'h06;
  localparam logic [5:0] FN_SRA  = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SEQ  = 6'h28;
  localparam logic [5:0] FN_SNE  = 6'h29;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SGT  = 6'h2b;
  localparam logic [5:0] FN_SLE  = 6'h2c;
  localparam logic [5:0] FN_SGE  = 6'h2d;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SEQ, ALU_SNE, ALU_SLT, ALU_SGT, ALU_SLE, ALU_SGE, ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {BR_NONE, BR_EQZ, BR_NEZ, BR_J, BR_JR} br_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  // rd == 0 marks an instruction that writes nothing (stores, branches, bubbles)
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    br_e         br;
    logic        use_imm;
    logic        link;
    logic        mem_read;
    logic        mem_write;
    logic        mem_b;
    logic        mem_h;
    logic        mem_uns;
  } idex_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        mem_b;
    logic        mem_h;
    logic        mem_uns;
  } exmem_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
  } memwb_t;

endpackage

// File: rtl/dlx_regfile.sv
// rtl/dlx_regfile.sv - 32x32 register file, 2 read / 1 write, r0 hardwired to zero
module dlx_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  output logic [31:0] rda_o,
  output logic [31:0] rdb_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Write-through: a WB write in this cycle is visible to ID reads in the same cycle
  always_comb begin
    rda_o = regs_q[ra_i];
    rdb_o = regs_q[rb_i];
    if (we_i && (wa_i != 5'd0) && (wa_i == ra_i)) rda_o = wd_i;
    if (we_i && (wa_i != 5'd0) && (wa_i == rb_i)) rdb_o = wd_i;
    if (ra_i == 5'd0) rda_o = '0;
    if (rb_i == 5'd0) rdb_o = '0;
  end

endmodule

// File: rtl/dlx_pipeline.sv
// rtl/dlx_pipeline.sv - 5-stage in-order DLX integer core with forwarding, load-use stall
// and branch resolution in EX
module dlx_pipeline
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] mem_read_data,
  output logic [31:0] PC,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_wr,
  output logic        mem_sh,
  output logic        mem_sb,
  output logic [31:0] busA_probe
);

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d, dec;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;

  logic [31:0] instr, imm_s, imm_z, imm_j, rf_a, rf_b;
  logic [5:0]  op, fn;
  logic [4:0]  id_rs1, id_rs2;
  logic        use_rs2, ialu, is_load, is_store, load_use;

  assign instr  = ifid_q.instr;
  assign op     = instr[31:26];
  assign fn     = instr[5:0];
  assign id_rs1 = instr[25:21];
  assign id_rs2 = instr[20:16];
  assign imm_s  = {{16{instr[15]}}, instr[15:0]};
  assign imm_z  = {16'h0, instr[15:0]};
  assign imm_j  = {{6{instr[25]}}, instr[25:0]};

  dlx_regfile u_regfile (
    .clk   (clk),
    .rst   (reset),
    .ra_i  (id_rs1),
    .rb_i  (id_rs2),
    .rda_o (rf_a),
    .rdb_o (rf_b),
    .we_i  (memwb_q.rd != 5'd0),
    .wa_i  (memwb_q.rd),
    .wd_i  (memwb_q.result)
  );

  always_comb begin
    dec      = '0;
    use_rs2  = 1'b0;
    ialu     = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    dec.pc4  = ifid_q.pc4;
    dec.a    = rf_a;
    dec.b    = rf_b;
    dec.rs1  = id_rs1;
    dec.rs2  = id_rs2;
    dec.imm  = imm_s;
    case (op)
      OP_RTYPE: begin
        use_rs2 = 1'b1;
        dec.rd  = instr[15:11];
        case (fn)
          FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
          FN_AND:          dec.alu_op = ALU_AND;
          FN_OR:           dec.alu_op = ALU_OR;
          FN_XOR:          dec.alu_op = ALU_XOR;
          FN_SLL:          dec.alu_op = ALU_SLL;
          FN_SRL:          dec.alu_op = ALU_SRL;
          FN_SRA:          dec.alu_op = ALU_SRA;
          FN_SEQ:          dec.alu_op = ALU_SEQ;
          FN_SNE:          dec.alu_op = ALU_SNE;
          FN_SLT:          dec.alu_op = ALU_SLT;
          FN_SGT:          dec.alu_op = ALU_SGT;
          FN_SLE:          dec.alu_op = ALU_SLE;
          FN_SGE:          dec.alu_op = ALU_SGE;
          default:         dec.rd     = 5'd0;
        endcase
      end
      OP_ADDI:  begin ialu = 1'b1; dec.alu_op = ALU_ADD; end
      OP_ADDUI: begin ialu = 1'b1; dec.alu_op = ALU_ADD; dec.imm = imm_z; end
      OP_SUBI:  begin ialu = 1'b1; dec.alu_op = ALU_SUB; end
      OP_SUBUI: begin ialu = 1'b1; dec.alu_op = ALU_SUB; dec.imm = imm_z; end
      OP_ANDI:  begin ialu = 1'b1; dec.alu_op = ALU_AND; dec.imm = imm_z; end
      OP_ORI:   begin ialu = 1'b1; dec.alu_op = ALU_OR;  dec.imm = imm_z; end
      OP_XORI:  begin ialu = 1'b1; dec.alu_op = ALU_XOR; dec.imm = imm_z; end
      OP_SLLI:  begin ialu = 1'b1; dec.alu_op = ALU_SLL; end
      OP_SRLI:  begin ialu = 1'b1; dec.alu_op = ALU_SRL; end
      OP_SRAI:  begin ialu = 1'b1; dec.alu_op = ALU_SRA; end
      OP_SEQI:  begin ialu = 1'b1; dec.alu_op = ALU_SEQ; end
      OP_SNEI:  begin ialu = 1'b1; dec.alu_op = ALU_SNE; end
      OP_SLTI:  begin ialu = 1'b1; dec.alu_op = ALU_SLT; end
      OP_SGTI:  begin ialu = 1'b1; dec.alu_op = ALU_SGT; end
      OP_SLEI:  begin ialu = 1'b1; dec.alu_op = ALU_SLE; end
      OP_SGEI:  begin ialu = 1'b1; dec.alu_op = ALU_SGE; end
      OP_LHI:   begin ialu = 1'b1; dec.alu_op = ALU_PASSB; dec.imm = {instr[15:0], 16'h0}; end
      OP_LB:    begin is_load = 1'b1; dec.mem_b = 1'b1; end
      OP_LBU:   begin is_load = 1'b1; dec.mem_b = 1'b1; dec.mem_uns = 1'b1; end
      OP_LH:    begin is_load = 1'b1; dec.mem_h = 1'b1; end
      OP_LHU:   begin is_load = 1'b1; dec.mem_h = 1'b1; dec.mem_uns = 1'b1; end
      OP_LW:    is_load = 1'b1;
      OP_SB:    begin is_store = 1'b1; dec.mem_b = 1'b1; end
      OP_SH:    begin is_store = 1'b1; dec.mem_h = 1'b1; end
      OP_SW:    is_store = 1'b1;
      OP_BEQZ:  dec.br = BR_EQZ;
      OP_BNEZ:  dec.br = BR_NEZ;
      OP_J:     begin dec.br = BR_J; dec.imm = imm_j; end
      OP_JAL:   begin dec.br = BR_J; dec.imm = imm_j; dec.link = 1'b1; dec.rd = 5'd31; end
      OP_JR:    dec.br = BR_JR;
      OP_JALR:  begin dec.br = BR_JR; dec.link = 1'b1; dec.rd = 5'd31; end
      default:  ;
    endcase
    if (ialu) begin
      dec.use_imm = 1'b1;
      dec.rd      = instr[20:16];
    end
    if (is_load) begin
      dec.use_imm  = 1'b1;
      dec.mem_read = 1'b1;
      dec.rd       = instr[20:16];
    end
    if (is_store) begin
      dec.use_imm   = 1'b1;
      dec.mem_write = 1'b1;
      use_rs2       = 1'b1;
    end
  end

  assign load_use = idex_q.mem_read && (idex_q.rd != 5'd0) &&
                    ((idex_q.rd == id_rs1) || (use_rs2 && (idex_q.rd == id_rs2)));

  logic [31:0] fwd_a, fwd_b, op_b, alu_y, ex_target;
  logic        taken;

  always_comb begin
    fwd_a = idex_q.a;
    fwd_b = idex_q.b;
    if ((exmem_q.rd != 5'd0) && (exmem_q.rd == idex_q.rs1))      fwd_a = exmem_q.result;
    else if ((memwb_q.rd != 5'd0) && (memwb_q.rd == idex_q.rs1)) fwd_a = memwb_q.result;
    if ((exmem_q.rd != 5'd0) && (exmem_q.rd == idex_q.rs2))      fwd_b = exmem_q.result;
    else if ((memwb_q.rd != 5'd0) && (memwb_q.rd == idex_q.rs2)) fwd_b = memwb_q.result;
  end

  assign op_b = idex_q.use_imm ? idex_q.imm : fwd_b;

  always_comb begin
    alu_y = op_b;
    case (idex_q.alu_op)
      ALU_ADD:   alu_y = fwd_a + op_b;
      ALU_SUB:   alu_y = fwd_a - op_b;
      ALU_AND:   alu_y = fwd_a & op_b;
      ALU_OR:    alu_y = fwd_a | op_b;
      ALU_XOR:   alu_y = fwd_a ^ op_b;
      ALU_SLL:   alu_y = fwd_a << op_b[4:0];
      ALU_SRL:   alu_y = fwd_a >> op_b[4:0];
      ALU_SRA:   alu_y = $unsigned($signed(fwd_a) >>> op_b[4:0]);
      ALU_SEQ:   alu_y = {31'd0, fwd_a == op_b};
      ALU_SNE:   alu_y = {31'd0, fwd_a != op_b};
      ALU_SLT:   alu_y = {31'd0, $signed(fwd_a) <  $signed(op_b)};
      ALU_SGT:   alu_y = {31'd0, $signed(fwd_a) >  $signed(op_b)};
      ALU_SLE:   alu_y = {31'd0, $signed(fwd_a) <= $signed(op_b)};
      ALU_SGE:   alu_y = {31'd0, $signed(fwd_a) >= $signed(op_b)};
      ALU_PASSB: alu_y = op_b;
      default:   alu_y = op_b;
    endcase
  end

  always_comb begin
    taken     = 1'b0;
    ex_target = idex_q.pc4 + idex_q.imm;
    case (idex_q.br)
      BR_EQZ:  taken = (fwd_a == 32'd0);
      BR_NEZ:  taken = (fwd_a != 32'd0);
      BR_J:    taken = 1'b1;
      BR_JR:   begin taken = 1'b1; ex_target = fwd_a; end
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    exmem_d.result     = idex_q.link ? idex_q.pc4 : alu_y;
    exmem_d.store_data = fwd_b;
    exmem_d.rd         = idex_q.rd;
    exmem_d.mem_read   = idex_q.mem_read;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.mem_b      = idex_q.mem_b;
    exmem_d.mem_h      = idex_q.mem_h;
    exmem_d.mem_uns    = idex_q.mem_uns;
  end

  logic [31:0] load_data;

  always_comb begin
    load_data = mem_read_data;
    if (exmem_q.mem_b)
      load_data = exmem_q.mem_uns ? {24'h0, mem_read_data[7:0]}
                                  : {{24{mem_read_data[7]}}, mem_read_data[7:0]};
    else if (exmem_q.mem_h)
      load_data = exmem_q.mem_uns ? {16'h0, mem_read_data[15:0]}
                                  : {{16{mem_read_data[15]}}, mem_read_data[15:0]};
    memwb_d.result = exmem_q.mem_read ? load_data : exmem_q.result;
    memwb_d.rd     = exmem_q.rd;
  end

  // A redirect squashes the younger instructions, which also discards any stall bubble
  always_comb begin
    pc_d         = pc_q + 32'd4;
    ifid_d.pc4   = pc_q + 32'd4;
    ifid_d.instr = instruction;
    idex_d       = dec;
    if (taken) begin
      pc_d   = ex_target;
      ifid_d = '0;
      idex_d = '0;
    end else if (load_use) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign PC             = pc_q;
  assign mem_addr       = exmem_q.result;
  assign mem_write_data = exmem_q.store_data;
  assign mem_wr         = exmem_q.mem_write;
  assign mem_sb         = exmem_q.mem_b;
  assign mem_sh         = exmem_q.mem_h;
  assign busA_probe     = rf_a;

endmodule

// File: tb/tb_dlx_pipeline.sv
// tb/tb_dlx_pipeline.sv - directed program run, PC trace, memory-port and register-dump checks
module tb_dlx_pipeline;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] mem_read_data;
  logic [31:0] PC;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_wr;
  logic        mem_sh;
  logic        mem_sb;
  logic [31:0] busA_probe;

  dlx_pipeline #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .instruction    (instruction),
    .mem_read_data  (mem_read_data),
    .PC             (PC),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_wr         (mem_wr),
    .mem_sh         (mem_sh),
    .mem_sb         (mem_sb),
    .busA_probe     (busA_probe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared;
  int mismatched;

  logic [31:0] imem [64];
  logic        force_en;
  logic [31:0] force_word;
  assign instruction = force_en ? force_word : imem[PC[7:2]];

  logic [7:0] dmem [256];
  logic       clear_ram;
  logic [7:0] ra;
  assign ra = mem_addr[7:0];

  always_comb begin
    if (mem_sb)      mem_read_data = {24'h0, dmem[ra]};
    else if (mem_sh) mem_read_data = {16'h0, dmem[ra], dmem[ra + 8'd1]};
    else             mem_read_data = {dmem[ra], dmem[ra + 8'd1], dmem[ra + 8'd2], dmem[ra + 8'd3]};
  end

  always @(posedge clk) begin
    if (clear_ram) begin
      for (int k = 0; k < 256; k++) dmem[k] <= 8'h00;
    end else if (mem_wr) begin
      if (mem_sb) dmem[ra] <= mem_write_data[7:0];
      else if (mem_sh) begin
        dmem[ra]        <= mem_write_data[15:8];
        dmem[ra + 8'd1] <= mem_write_data[7:0];
      end else begin
        dmem[ra]        <= mem_write_data[31:24];
        dmem[ra + 8'd1] <= mem_write_data[23:16];
        dmem[ra + 8'd2] <= mem_write_data[15:8];
        dmem[ra + 8'd3] <= mem_write_data[7:0];
      end
    end
  end

  int          wr_cnt = 0;
  int          sb_cnt = 0;
  int          sb_bad = 0;
  int          sh_cnt = 0;
  logic [31:0] wr_log [8];

  always @(negedge clk) begin
    if (mem_wr) begin
      if (wr_cnt < 8) wr_log[wr_cnt] = mem_addr;
      wr_cnt = wr_cnt + 1;
    end
    if (mem_sb) begin
      sb_cnt = sb_cnt + 1;
      if (mem_addr != 32'd3) sb_bad = sb_bad + 1;
    end
    if (mem_sh) sh_cnt = sh_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs1,
                                     input logic [4:0] rd, input logic [15:0] imm);
    return {op, rs1, rd, imm};
  endfunction

  function automatic logic [31:0] rt(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs1, rs2, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] jt(input logic [5:0] op, input logic [25:0] off);
    return {op, off};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [32];
  logic [31:0] exp_pc [31];

  task automatic dump(input bit expect_zero);
    for (int i = 0; i < 32; i++) begin
      force_word = tbl[i].instr;
      @(posedge clk); #1;
      check($sformatf("%s_r%0d", expect_zero ? "post_reset" : "dump", i), busA_probe,
            expect_zero ? 32'd0 : tbl[i].exp);
    end
  endtask

  int w0;

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    clear_ram  = 1'b1;
    force_en   = 1'b0;
    force_word = 32'h0;

    for (int k = 0; k < 64; k++) imem[k] = 32'h0;
    imem[0]  = it(6'h08, 5'd0, 5'd1, 16'd5);        // addi r1,r0,5
    imem[1]  = it(6'h08, 5'd0, 5'd2, 16'hFFFD);     // addi r2,r0,-3
    imem[2]  = rt(5'd1, 5'd2, 5'd3, 6'h20);         // add  r3,r1,r2
    imem[3]  = it(6'h0F, 5'd0, 5'd4, 16'h1234);     // lhi  r4,0x1234
    imem[4]  = it(6'h0D, 5'd4, 5'd4, 16'h5678);     // ori  r4,r4,0x5678
    imem[5]  = it(6'h2B, 5'd0, 5'd4, 16'd0);        // sw   0(r0),r4
    imem[6]  = it(6'h23, 5'd0, 5'd5, 16'd0);        // lw   r5,0(r0)
    imem[7]  = it(6'h08, 5'd5, 5'd6, 16'd1);        // addi r6,r5,1
    imem[8]  = it(6'h08, 5'd0, 5'd9, 16'h0080);     // addi r9,r0,0x80
    imem[9]  = it(6'h28, 5'd0, 5'd9, 16'd3);        // sb   3(r0),r9
    imem[10] = it(6'h20, 5'd0, 5'd7, 16'd3);        // lb   r7,3(r0)
    imem[11] = it(6'h24, 5'd0, 5'd8, 16'd3);        // lbu  r8,3(r0)
    imem[12] = it(6'h04, 5'd0, 5'd0, 16'd8);        // beqz r0,+8
    imem[13] = it(6'h08, 5'd0, 5'd10, 16'd1);       // flushed
    imem[14] = it(6'h08, 5'd0, 5'd11, 16'd1);       // flushed
    imem[15] = it(6'h05, 5'd0, 5'd0, 16'd8);        // bnez r0,+8
    imem[16] = it(6'h08, 5'd0, 5'd12, 16'd7);       // addi r12,r0,7
    imem[17] = jt(6'h03, 26'd8);                    // jal  -> 80
    imem[18] = it(6'h08, 5'd0, 5'd13, 16'd9);       // addi r13,r0,9
    imem[19] = jt(6'h02, 26'd8);                    // j    -> 88
    imem[20] = it(6'h08, 5'd0, 5'd14, 16'd3);       // addi r14,r0,3
    imem[21] = it(6'h12, 5'd31, 5'd0, 16'd0);       // jr   r31
    imem[22] = jt(6'h02, 26'h3FF_FFFC);             // j    self

    for (int i = 0; i < 32; i++) begin
      tbl[i].instr = {6'h08, i[4:0], 5'd0, 16'd0};
      tbl[i].exp   = 32'd0;
    end
    tbl[1].exp  = 32'd5;
    tbl[2].exp  = 32'hFFFF_FFFD;
    tbl[3].exp  = 32'd2;
    tbl[4].exp  = 32'h1234_5678;
    tbl[5].exp  = 32'h1234_5678;
    tbl[6].exp  = 32'h1234_5679;
    tbl[7].exp  = 32'hFFFF_FF80;
    tbl[8].exp  = 32'h0000_0080;
    tbl[9].exp  = 32'h0000_0080;
    tbl[12].exp = 32'd7;
    tbl[13].exp = 32'd9;
    tbl[14].exp = 32'd3;
    tbl[31].exp = 32'd72;

    exp_pc = '{32'd0,  32'd4,  32'd8,  32'd12, 32'd16, 32'd20, 32'd24, 32'd28,
               32'd32, 32'd32, 32'd36, 32'd40, 32'd44, 32'd48, 32'd52, 32'd56,
               32'd60, 32'd64, 32'd68, 32'd72, 32'd76, 32'd80, 32'd84, 32'd88,
               32'd92, 32'd72, 32'd76, 32'd80, 32'd84, 32'd88, 32'd92};

    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", PC, 32'd0);
    check("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("reset_mem_sb", {31'd0, mem_sb}, 32'd0);
    check("reset_mem_sh", {31'd0, mem_sh}, 32'd0);
    check("reset_busA", busA_probe, 32'd0);

    clear_ram = 1'b0;
    reset     = 1'b0;
    for (int k = 0; k < 31; k++) begin
      check($sformatf("pc_trace_c%0d", k), PC, exp_pc[k]);
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk);
    #1;

    force_en   = 1'b1;
    force_word = 32'h0;
    repeat (6) @(posedge clk);
    #1;

    check("store_count", wr_cnt, 32'd2);
    check("sw_addr", wr_log[0], 32'd0);
    check("sb_addr", wr_log[1], 32'd3);
    check("sb_cycles", sb_cnt, 32'd3);
    check("sb_bad_addr", sb_bad, 32'd0);
    check("sh_cycles", sh_cnt, 32'd0);
    check("ram_word0", {dmem[0], dmem[1], dmem[2], dmem[3]}, 32'h1234_5680);

    dump(1'b0);

    reset     = 1'b1;
    clear_ram = 1'b1;
    force_en  = 1'b0;
    @(posedge clk); #1;
    clear_ram = 1'b0;
    @(posedge clk); #1;
    w0    = wr_cnt;
    reset = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("rerun_sw_in_mem", {31'd0, mem_wr}, 32'd1);
    check("rerun_sw_addr", mem_addr, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("midreset_pc", PC, 32'd0);
    check("midreset_mem_wr", {31'd0, mem_wr}, 32'd0);
    force_en   = 1'b1;
    force_word = 32'h0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("dropped_store_count", wr_cnt - w0, 32'd0);
    check("dropped_store_ram", {dmem[0], dmem[1], dmem[2], dmem[3]}, 32'd0);

    dump(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
